add_seq_chk: RTL
================

// Module: add_seq_chk
// PURPOSE
//  Receive-side checker for the 12-bit address/terminal-count stream from the address generator.
//  Predicts the next address from the previous sample and the advance strobe; flags skips, repeats and bad tc.
//  Counts completed frames (0xFFF->0x000 wraps) and errors for status registers and BIST.
//  Sits beside the memory it addresses, on the same clock as the generator.
// PARAMETERS
//  AW          12  address width; all-ones is terminal count
//  ECW         8   error counter width, saturating
//  FCW         16  frame counter width, wraps
//  FAULT_STOP  0   1: first error parks FSM in FAULT until clr; 0: resync and keep checking
// PORTS
//  clock      in   1    system clock, rising edge
//  reset      in   1    synchronous, active-high; all state to reset values
//  chk_en     in   1    level; 1 = checking enabled
//  clr        in   1    pulse; clears counters, sticky flags, captured address
//  adv_n      in   1    generator advance strobe, active-low (0 = generator counts this edge)
//  addr_in    in   AW   generator address
//  tc_in      in   1    generator terminal count
//  locked     out  1    FSM in TRACK
//  err        out  1    one-cycle pulse per detected error
//  tc_err     out  1    sticky; tc_in != (addr_in == all-ones) seen while TRACK
//  seq_err    out  1    sticky; address mismatch seen while TRACK
//  err_cnt    out  ECW  error count, saturates at all-ones
//  bad_addr   out  AW   addr_in of first error since reset/clr
//  frame_done out  1    one-cycle pulse on a correct all-ones -> zero wrap
//  frame_cnt  out  FCW  completed frames, wraps modulo 2^FCW
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE. prev_addr = 0, prev_adv_n = 1.
//  FSM states: IDLE, ACQ, TRACK, FAULT.
//   IDLE: chk_en=1 -> ACQ.
//   ACQ: capture addr_in and adv_n; no checks; -> TRACK.
//   TRACK: check every cycle. Error and FAULT_STOP=1 -> FAULT.
//   FAULT: no checks. clr=1 -> ACQ.
//   Any state: chk_en=0 -> IDLE (counters and sticky flags hold).
//  prev_addr and prev_adv_n register addr_in and adv_n every cycle in ACQ and TRACK.
//  exp = (prev_addr + !prev_adv_n) mod 2^AW; 0xFFF + 1 -> 0x000 is legal, not an error.
//  seq mismatch: addr_in != exp. tc mismatch: tc_in != &addr_in.
//  Both mismatches in one cycle count as one error: err pulse, err_cnt +1; both sticky flags set.
//  Error reporting is registered: err, sticky flags, err_cnt and bad_addr update on the edge after the offending sample.
//  FAULT_STOP=0: after an error, the received value becomes prev_addr (resync); no cascaded errors.
//  frame_done: TRACK, prev_addr = all-ones, !prev_adv_n, addr_in = 0. Pulses one cycle after that sample; frame_cnt +1.
//  Stall (adv_n=1): the same address is expected again. Long stalls are legal.
//  clr priority: clr beats an error or frame event in the same cycle.
//   That event is discarded; counters, flags and bad_addr go to 0.
//   clr in TRACK -> ACQ (re-acquire).
//  reset beats clr and chk_en. reset mid-frame: everything returns to reset values next edge.
// STRUCTURE
//  Package add_chk_pkg: FSM state encodings (localparams S_IDLE..S_FAULT, 2 bits).
//  Sub-module add_chk_pred: registers prev_addr/prev_adv_n, outputs exp and wrap flag (combinational compare).
//  FSM, counters and sticky logic live in the top level.
// TESTING
//  1 reset, chk_en=1, stream 0..0xFFF, adv_n=0 each cycle, tc at 0xFFF -> err never 1; frame_done once; frame_cnt=1.
//  2 adv_n=1 for 5 cycles at 0x123, address held -> no error. Then skip 0x124->0x126 -> err 1 cycle; err_cnt=1; bad_addr=0x126; seq_err=1.
//  3 tc_in=1 at addr 0x7FE -> tc_err=1, err_cnt=1. With FAULT_STOP=1: locked=0, FSM FAULT until clr, then locked one cycle after ACQ.
//  4 inject 300 errors -> err_cnt saturates at 0xFF; the next error keeps 0xFF and still pulses err.
//  5 clr in the same cycle as a skip -> err stays 0; counters 0; FSM re-acquires with no spurious error.
//  6 reset mid-frame at 0x800 -> all outputs 0 next edge; chk_en held 1 -> ACQ then TRACK; no false errors.

Source files
------------

// File: rtl/add_chk_pkg.sv
// Shared definitions for the address-sequence checker: FSM state encodings.
package add_chk_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ACQ   = S_ACQ,
    ST_TRACK = S_TRACK,
    ST_FAULT = S_FAULT
  } chk_state_e;

endpackage

// File: rtl/add_chk_pred.sv
// Next-address predictor: remembers the previous sample and advance strobe,
// and presents the expected address plus a flag for the all-ones -> zero wrap.
module add_chk_pred #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic          adv_n_i,
  output logic [AW-1:0] exp_o,
  output logic          wrap_o
);

  logic [AW-1:0] prev_addr_q;
  logic          prev_adv_n_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_addr_q  <= '0;
      prev_adv_n_q <= 1'b1;
    end else if (load_i) begin
      prev_addr_q  <= addr_i;
      prev_adv_n_q <= adv_n_i;
    end
  end

  // Modulo-2^AW add makes the terminal-count wrap a legal prediction.
  assign exp_o  = prev_addr_q + {{(AW-1){1'b0}}, ~prev_adv_n_q};
  assign wrap_o = (&prev_addr_q) & ~prev_adv_n_q;

endmodule

// File: rtl/add_seq_chk.sv
// Receive-side checker for the address/terminal-count stream: tracks the
// generator, reports skips/repeats/bad tc, and counts frames and errors.
module add_seq_chk
  import add_chk_pkg::*;
#(
  parameter int AW         = 12,
  parameter int ECW        = 8,
  parameter int FCW        = 16,
  parameter bit FAULT_STOP = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           chk_en,
  input  logic           clr,
  input  logic           adv_n,
  input  logic [AW-1:0]  addr_in,
  input  logic           tc_in,
  output logic           locked,
  output logic           err,
  output logic           tc_err,
  output logic           seq_err,
  output logic [ECW-1:0] err_cnt,
  output logic [AW-1:0]  bad_addr,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt
);

  chk_state_e     state_q, state_d;
  logic           err_q, err_d;
  logic           tc_err_q, tc_err_d;
  logic           seq_err_q, seq_err_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0]  bad_addr_q, bad_addr_d;
  logic           frame_done_q, frame_done_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  logic [AW-1:0]  exp_addr;
  logic           wrap;
  logic           pred_load;
  logic           checking;
  logic           seq_mis;
  logic           tc_mis;
  logic           err_hit;
  logic           frame_hit;

  assign pred_load = (state_q == ST_ACQ) || (state_q == ST_TRACK);

  add_chk_pred #(.AW(AW)) u_pred (
    .clock   (clock),
    .reset   (reset),
    .load_i  (pred_load),
    .addr_i  (addr_in),
    .adv_n_i (adv_n),
    .exp_o   (exp_addr),
    .wrap_o  (wrap)
  );

  // Resync is implicit: the predictor reloads every TRACK cycle, even on error.
  assign checking  = (state_q == ST_TRACK) && chk_en;
  assign seq_mis   = (addr_in != exp_addr);
  assign tc_mis    = (tc_in != (&addr_in));
  assign err_hit   = checking && (seq_mis || tc_mis);
  assign frame_hit = checking && wrap && (addr_in == '0) && !tc_mis;

  always_comb begin
    state_d = state_q;
    if (!chk_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ACQ;
        ST_ACQ:   state_d = ST_TRACK;
        ST_TRACK: begin
          if (clr)                        state_d = ST_ACQ;
          else if (err_hit && FAULT_STOP) state_d = ST_FAULT;
        end
        ST_FAULT: if (clr) state_d = ST_ACQ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err_d        = err_hit && !clr;
    frame_done_d = frame_hit && !clr;
    tc_err_d     = tc_err_q;
    seq_err_d    = seq_err_q;
    err_cnt_d    = err_cnt_q;
    bad_addr_d   = bad_addr_q;
    frame_cnt_d  = frame_cnt_q;
    if (clr) begin
      tc_err_d    = 1'b0;
      seq_err_d   = 1'b0;
      err_cnt_d   = '0;
      bad_addr_d  = '0;
      frame_cnt_d = '0;
    end else begin
      if (err_hit) begin
        tc_err_d  = tc_err_q | tc_mis;
        seq_err_d = seq_err_q | seq_mis;
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ECW'(1);
        // No sticky flag yet means this is the first error since reset/clr.
        if (!(tc_err_q || seq_err_q)) bad_addr_d = addr_in;
      end
      if (frame_hit) frame_cnt_d = frame_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      tc_err_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      bad_addr_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      tc_err_q     <= tc_err_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      bad_addr_q   <= bad_addr_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign locked     = (state_q == ST_TRACK);
  assign err        = err_q;
  assign tc_err     = tc_err_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;
  assign bad_addr   = bad_addr_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
